// File: rtl/booth_pp_accumulator.sv
// Multi-cycle summation of one radix-4 Booth partial-product set (17 terms plus correction bits) into a 64-bit product.
// Latency: N = ceil(17/PP_PER_CYCLE) cycles from capture to Out_Valid, or 1..N with BOOTH_PP_ACC_EARLY_EXIT_EN defined.
// Backpressure: In_Ready only in IDLE; Product/Out_Valid held in DONE until Out_Ready, then back to IDLE.
module booth_pp_accumulator #(
  parameter int PP_PER_CYCLE = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [33:0] PP0,
  input  logic [33:0] PP1,
  input  logic [33:0] PP2,
  input  logic [33:0] PP3,
  input  logic [33:0] PP4,
  input  logic [33:0] PP5,
  input  logic [33:0] PP6,
  input  logic [33:0] PP7,
  input  logic [33:0] PP8,
  input  logic [33:0] PP9,
  input  logic [33:0] PP10,
  input  logic [33:0] PP11,
  input  logic [33:0] PP12,
  input  logic [33:0] PP13,
  input  logic [33:0] PP14,
  input  logic [33:0] PP15,
  input  logic [31:0] PP16,
  input  logic [15:0] Error_Correction,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [63:0] Product,
  output logic        Busy
);

  localparam int N  = (17 + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
  localparam int NT = N * PP_PER_CYCLE;
  localparam int IW = $clog2(NT);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t          state, state_nxt;
  logic [33:0]     pp_r [16];
  logic [31:0]     pp16_r;
  logic [15:0]     ec_r;
  logic [63:0]     acc;
  logic [63:0]     grp;
  logic [63:0]     acc_sum;
  logic [IW-1:0]   idx;
  logic [63:0]     t [NT];
  logic            last_grp;
  logic            finish;

  // Term table padded with zeros so every group reads a full PP_PER_CYCLE slots.
  always_comb begin
    for (int i = 0; i < NT; i++) t[i] = '0;
    for (int i = 0; i < 16; i++)
      t[i] = ({{30{pp_r[i][33]}}, pp_r[i]} + {63'd0, ec_r[i]}) << (2 * i);
    t[16] = {pp16_r, 32'd0};
  end

  always_comb begin
    grp = '0;
    for (int j = 0; j < PP_PER_CYCLE; j++)
      grp = grp + t[idx + IW'(j)];
  end

  assign acc_sum  = acc + grp;
  assign last_grp = (int'(idx) + PP_PER_CYCLE >= 17);

`ifdef BOOTH_PP_ACC_EARLY_EXIT_EN
  logic rem_zero;

  always_comb begin
    rem_zero = (pp16_r == '0);
    for (int k = 0; k < 16; k++)
      if (k >= int'(idx) && (pp_r[k] != '0 || ec_r[k]))
        rem_zero = 1'b0;
  end

  assign finish = last_grp || rem_zero;
`else
  assign finish = last_grp;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    Busy      = 1'b1;
    case (state)
      IDLE: begin
        In_Ready = 1'b1;
        Busy     = 1'b0;
        if (In_Valid) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc     <= '0;
      idx     <= '0;
      Product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid) begin
            pp_r[0]  <= PP0;
            pp_r[1]  <= PP1;
            pp_r[2]  <= PP2;
            pp_r[3]  <= PP3;
            pp_r[4]  <= PP4;
            pp_r[5]  <= PP5;
            pp_r[6]  <= PP6;
            pp_r[7]  <= PP7;
            pp_r[8]  <= PP8;
            pp_r[9]  <= PP9;
            pp_r[10] <= PP10;
            pp_r[11] <= PP11;
            pp_r[12] <= PP12;
            pp_r[13] <= PP13;
            pp_r[14] <= PP14;
            pp_r[15] <= PP15;
            pp16_r   <= PP16;
            ec_r     <= Error_Correction;
            acc      <= '0;
            idx      <= '0;
          end
        end
        ACCUM: begin
          // On an early exit the remaining group is all zeros, so acc_sum equals acc.
          if (finish) begin
            Product <= acc_sum;
          end else begin
            acc <= acc_sum;
            idx <= idx + IW'(PP_PER_CYCLE);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator at PP_PER_CYCLE = 2; honours BOOTH_PP_ACC_EARLY_EXIT_EN for latency.
module tb_booth_pp_accumulator;

  localparam int P = 2;
  localparam int N = 9;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        In_Valid;
  logic        In_Ready;
  logic [33:0] pp [16];
  logic [31:0] pp16;
  logic [15:0] ec;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [63:0] Product;
  logic        Busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  booth_pp_accumulator #(.PP_PER_CYCLE(P)) dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .PP0(pp[0]), .PP1(pp[1]), .PP2(pp[2]), .PP3(pp[3]),
    .PP4(pp[4]), .PP5(pp[5]), .PP6(pp[6]), .PP7(pp[7]),
    .PP8(pp[8]), .PP9(pp[9]), .PP10(pp[10]), .PP11(pp[11]),
    .PP12(pp[12]), .PP13(pp[13]), .PP14(pp[14]), .PP15(pp[15]),
    .PP16(pp16), .Error_Correction(ec),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Product(Product), .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 16; i++) pp[i] = '0;
    pp16 = '0;
    ec   = '0;
  endtask

  // Cycles from capture to Out_Valid implied by the highest nonzero term.
  function automatic int exp_lat();
    int l;
    int m;
    l = -1;
    for (int i = 0; i < 16; i++) if (pp[i] != '0 || ec[i]) l = i;
    if (pp16 != '0) l = 16;
    m = N;
`ifdef BOOTH_PP_ACC_EARLY_EXIT_EN
    if (l < 0) m = 1;
    else m = (l / P + 2 > N) ? N : l / P + 2;
`endif
    return m;
  endfunction

  // Radix-4 Booth encoding of a*b, matching the generator's term layout.
  task automatic booth_gen(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [33:0] a34;
    logic [32:0] bx;
    logic [2:0]  tri3;
    logic [33:0] mag;
    logic        neg;
    a34 = sgn ? {{2{a[31]}}, a} : {2'b00, a};
    bx  = {b, 1'b0};
    for (int i = 0; i < 16; i++) begin
      tri3 = bx[2*i+2 -: 3];
      case (tri3)
        3'b001, 3'b010: begin mag = a34;      neg = 1'b0; end
        3'b011:         begin mag = a34 << 1; neg = 1'b0; end
        3'b100:         begin mag = a34 << 1; neg = 1'b1; end
        3'b101, 3'b110: begin mag = a34;      neg = 1'b1; end
        default:        begin mag = '0;       neg = 1'b0; end
      endcase
      pp[i] = neg ? ~mag : mag;
      ec[i] = neg;
    end
    pp16 = (!sgn && b[31]) ? a : 32'd0;
  endtask

  task automatic run_op(input string tag, input logic [63:0] exp_prod);
    int lat;
    int cnt;
    lat = exp_lat();
    In_Valid  = 1'b1;
    Out_Ready = 1'b1;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    chk1({tag, "_busy"}, Busy, 1'b1);
    chk1({tag, "_inrdy_lo"}, In_Ready, 1'b0);
    cnt = 0;
    while (!Out_Valid && cnt < 40) begin
      @(posedge Clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, 64'(cnt), 64'(lat));
    chk({tag, "_prod"}, Product, exp_prod);
    @(posedge Clk); #1;
    chk1({tag, "_ovld_lo"}, Out_Valid, 1'b0);
    chk1({tag, "_inrdy_hi"}, In_Ready, 1'b1);
    chk({tag, "_prod_held"}, Product, exp_prod);
  endtask

  initial begin
    int cnt;
    Rst = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b1;
    clear_inputs();
    repeat (2) @(posedge Clk);
    #1;
    chk1("rst_inrdy", In_Ready, 1'b1);
    chk1("rst_ovld", Out_Valid, 1'b0);
    chk1("rst_busy", Busy, 1'b0);
    chk("rst_prod", Product, 64'h0);
    Rst = 1'b0;
    @(posedge Clk); #1;

    clear_inputs(); pp[0] = 34'h5;
    run_op("pp0", 64'h5);
    clear_inputs();
    run_op("zero", 64'h0);
    clear_inputs(); pp[15] = 34'h1;
    run_op("pp15", 64'h4000_0000);
    clear_inputs(); pp[0] = 34'h3_FFFF_FFFA; ec = 16'h0001;
    run_op("neg_ec", 64'hFFFF_FFFF_FFFF_FFFB);
    clear_inputs(); pp16 = 32'hFFFF_FFFF;
    run_op("pp16", 64'hFFFF_FFFF_0000_0000);
    booth_gen(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("booth_u", 64'hFFFF_FFFE_0000_0001);
    booth_gen(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("booth_s", 64'h1);

    // Output stall with pulsed In_Valid that must be dropped.
    clear_inputs(); pp[3] = 34'h7;
    In_Valid = 1'b1; Out_Ready = 1'b0;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    cnt = 0;
    while (!Out_Valid && cnt < 40) begin
      @(posedge Clk); #1;
      cnt++;
    end
    chk("bp_prod", Product, 64'h1C0);
    pp[0] = 34'h1234;
    for (int k = 0; k < 5; k++) begin
      In_Valid = (k % 2 == 0);
      @(posedge Clk); #1;
      chk1("bp_ovld", Out_Valid, 1'b1);
      chk1("bp_inrdy", In_Ready, 1'b0);
      chk("bp_prod_stable", Product, 64'h1C0);
    end
    In_Valid = 1'b0; Out_Ready = 1'b1;
    @(posedge Clk); #1;
    chk1("bp_ovld_lo", Out_Valid, 1'b0);
    chk1("bp_inrdy_hi", In_Ready, 1'b1);
    @(posedge Clk); #1;
    chk1("bp_no_queue", Busy, 1'b0);

    // Reset in the 4th accumulation cycle discards the operation.
    clear_inputs(); pp[15] = 34'h1;
    In_Valid = 1'b1;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    chk1("mid_busy", Busy, 1'b1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk1("mid_rst_busy", Busy, 1'b0);
    chk1("mid_rst_ovld", Out_Valid, 1'b0);
    chk("mid_rst_prod", Product, 64'h0);
    chk1("mid_rst_inrdy", In_Ready, 1'b1);

    clear_inputs(); pp[0] = 34'h3_FFFF_FFFA; ec = 16'h0001;
    run_op("after_rst", 64'hFFFF_FFFF_FFFF_FFFB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/booth_pp_accumulator.md
Name: booth_pp_accumulator

Overview:
- Sequential consumer of the radix-4 Booth partial-product generator output: PP0..PP15, PP16 and Error_Correction.
- Captures one complete partial-product set, then sums it over several cycles, PP_PER_CYCLE terms per cycle, into a 64-bit product.
- The product is presented on a valid/ready output port.
- Area-lean alternative to a full combinational reduction tree; sits between the PP generator and the multiplier result register.

Parameters:
- PP_PER_CYCLE, 2, number of partial-product terms added per accumulation cycle; legal values 1, 2, 3, 6, 9, 17.
- N (localparam), ceil(17/PP_PER_CYCLE), number of accumulation cycles; 9 at default.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- In_Valid  input  1  PP set on inputs is valid
- In_Ready  output  1  block can accept a PP set
- PP0..PP15  input  34 each  Booth partial products, two's complement, weight 2^(2i)
- PP16  input  32  unsigned correction term, weight 2^32
- Error_Correction  input  16  bit i adds +1 at weight 2^(2i)
- Out_Valid  output  1  Product is valid
- Out_Ready  input  1  downstream accepts Product
- Product  output  64  sum modulo 2^64
- Busy  output  1  state != IDLE

Behaviour:
- Reset: Rst sampled high on a rising edge forces:
  - state = IDLE; In_Ready = 1.
  - Out_Valid = 0; Busy = 0; Product = 0.
  - Accumulator and term index cleared.
  - Any in-flight operation is discarded; no partial result is ever presented.
- Term list, in index order:
  - t0..t15 = sign-extend(PPi[33:0]) << 2i, plus Error_Correction[i] << 2i.
  - t16 = zero-extend(PP16) << 32.
  - All arithmetic is 64-bit, wrap modulo 2^64.
  - PPs are always sign-extended from bit 33; the Booth generator already encodes signed/unsigned mode, so no Sign input is needed.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - In_Ready = 1.
  - On In_Valid && In_Ready: register all 17 PPs and Error_Correction; acc = 0; idx = 0; go to ACCUM.
- ACCUM:
  - In_Ready = 0; inputs are ignored.
  - Each edge: acc += t[idx] + ... + t[idx+PP_PER_CYCLE-1]; indices > 16 contribute 0; idx += PP_PER_CYCLE.
  - On the edge that processes the last group (idx + PP_PER_CYCLE >= 17): Product <= final sum; Out_Valid <= 1; go to DONE.
- DONE:
  - Product and Out_Valid are held stable while Out_Ready = 0.
  - On Out_Valid && Out_Ready: Out_Valid <= 0; go to IDLE.
  - Product keeps its last value after the handshake.
- Latency: capture at edge E; Out_Valid rises at edge E+N.
- Throughput: minimum initiation interval is N+2 cycles. A new capture happens no earlier than the cycle after the output handshake; no overlap of DONE and capture.
- Simultaneous events:
  - Rst overrides every handshake.
  - In_Valid outside IDLE is ignored and carries no queued data.
  - The upstream source must hold its data until In_Ready.

Optional Feature:
- Macro: BOOTH_PP_ACC_EARLY_EXIT_EN.
- Defined:
  - In ACCUM, if every remaining term (index >= idx) is zero (PP bits, Error_Correction bits and PP16 all zero), the current edge goes directly to DONE with Product = acc.
  - The zero check is done on the registered copies.
  - Latency is variable, from 1 to N cycles; the result is identical to the full run.
- Undefined: fixed latency of N cycles; no zero-detect logic is synthesised.

Test Plan (PP_PER_CYCLE = 2):
- Zero set: all PPs, PP16 and Error_Correction = 0 → Out_Valid at edge E+9 (E+1 with the macro); Product = 64'h0.
- Single term: PP0 = 34'h5, rest 0 → Product = 64'h5. PP15 = 34'h1 → Product = 64'h4000_0000.
- Negative with correction: PP0 = 34'h3_FFFF_FFFA, Error_Correction = 16'h0001 → Product = 64'hFFFF_FFFF_FFFF_FFFB.
- PP16 only: PP16 = 32'hFFFF_FFFF → Product = 64'hFFFF_FFFF_0000_0000.
- End to end: drive inputs from the Booth generator with Multiplicand = Multiplier = 32'hFFFF_FFFF.
  - Sign = 0 → Product = 64'hFFFF_FFFE_0000_0001.
  - Sign = 1 → Product = 64'h1.
- Backpressure and reset:
  - Hold Out_Ready = 0 for 5 cycles → Product and Out_Valid stable, In_Ready = 0, pulsed In_Valid ignored.
  - Then assert Rst during the 4th ACCUM cycle of a new operation → next cycle IDLE, Out_Valid = 0, Product = 0, In_Ready = 1.
  - A following operation yields the correct result.
